uart_tx_btn: RTL
================

Name: uart_tx_btn

Overview:
- Downstream consumer of the 4-bit debounced button bus.
- Detects a rising edge on debounced button 0 and latches an 8-bit switch value.
- Serialises the byte as an 8N1 UART frame on tx, LSB first, at a fixed clocks-per-bit rate.
- Provides busy/done status for LEDs or a host FSM.

Parameters:
- CLKS_PER_BIT, 5208, cclk cycles per UART bit; 50 MHz / 9600 baud; legal range 2..65535.
- CNT_W, 16, width of baud counter; must hold CLKS_PER_BIT-1.

Ports:
- cclk  input  1  system clock, all logic on rising edge.
- clr  input  1  asynchronous reset, active-low (clr=0 resets).
- btn  input  4  debounced buttons; only btn[0] used as send trigger, btn[3:1] ignored.
- sw  input  8  byte to transmit, sampled on trigger cycle.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high from the cycle after trigger until the end of the stop bit.
- done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (clr=0, async): state=IDLE, tx=1, busy=0, done=0, baud_cnt=0, bit_idx=0, shreg=0, btn_q=1.
- btn_q resets to 1 so a button held during reset release does not send; a release then press is needed.
- Edge detect: btn_q <= btn[0] every cycle in all states; trig = btn[0] & ~btn_q.
- IDLE: tx=1, busy=0. On trig: shreg <= sw, baud_cnt <= 0, go to START.
- START: tx=0, busy=1. Hold CLKS_PER_BIT cycles; then bit_idx <= 0 and go to DATA.
- DATA: tx=shreg[0]. Each bit is held CLKS_PER_BIT cycles, then shreg shifts right.
- DATA: after bit_idx=7 completes, go to STOP (or PARITY, see optional feature); otherwise bit_idx increments.
- STOP: tx=1. Hold CLKS_PER_BIT cycles. On the last cycle: done=1 for one cycle, busy=0, return to IDLE.
- Latency: tx falls on the first rising cclk edge after the cycle in which trig is high.
- Frame length: exactly 10*CLKS_PER_BIT cycles from tx falling to done (11*CLKS_PER_BIT with parity).
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary. No drift; no fractional accumulation.
- trig while not IDLE is ignored and not queued. Exception: trig in the same cycle that done is high is also ignored.
- sw changes after the trigger cycle do not affect the frame in flight.
- Reset mid-frame: tx returns to 1 immediately (async); no done pulse; the partial frame is abandoned.
- Back-to-back: a new trig accepted in the first IDLE cycle after done starts a new frame. Minimum inter-frame idle is 1 cycle plus edge-detect time.
- Outputs tx, busy and done are registered; no combinational path from inputs.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = even parity (XOR of the latched byte) for CLKS_PER_BIT cycles. Frame becomes 11*CLKS_PER_BIT.
- Undefined: no parity state and no parity logic; plain 8N1.

Test Plan:
- CLKS_PER_BIT=4, sw=8'hA5, pulse btn[0] 0->1 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. done pulses at cycle 40 after tx falls; busy high for 40 cycles.
- Hold btn[0]=1 through reset release -> no frame (tx stays 1). Release then press -> one frame.
- Assert btn[0] again mid-frame, and change sw to 8'hFF mid-frame -> frame still carries 8'hA5, no second frame, done pulses once.
- Assert clr=0 during DATA bit 3 -> tx=1 and busy=0 asynchronously, done never pulses. After clr=1 and a new press, a full correct frame is sent.
- Two presses spaced so the second lands 2 cycles after done, sw=8'h00 then 8'hFF -> two complete frames, second all-ones data.
- With UART_TX_PARITY_EN, sw=8'h07 -> parity bit 1, frame 44 cycles at CLKS_PER_BIT=4. With sw=8'h03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_btn.sv
// Button-triggered UART transmitter: rising edge on btn[0] latches sw and sends it as an 8N1 frame on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_btn #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       cclk,
    input  logic       clr,
    input  logic [3:0] btn,
    input  logic [7:0] sw,
    output logic       tx,
    output logic       busy,
    output logic       done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shreg;
    logic             r_btn_q;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
`ifdef UART_TX_PARITY_EN
    logic             r_par;
`endif

    logic w_trig;
    logic w_last;
    logic w_unused;

    assign w_trig   = btn[0] & ~r_btn_q;
    assign w_last   = (r_cnt == LAST_CNT);
    assign w_unused = &{1'b0, btn[3:1]};

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

    // r_btn_q resets high so a button held through reset release cannot start a frame.
    always_ff @(posedge cclk or negedge clr) begin
        if (!clr) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_btn_q   <= 1'b1;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_btn_q <= btn[0];
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    // A trigger coinciding with the done pulse is dropped.
                    if (w_trig && !r_done) begin
                        r_shreg <= sw;
                        r_cnt   <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^sw;
`endif
                    end
                end
                S_START: begin
                    if (w_last) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shreg[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shreg   <= {1'b0, r_shreg[7:1]};
                            r_tx      <= r_shreg[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
